// File: rtl/sum_launcher.sv
// Launch stage for the HLS `sum` kernel: accepts n, pulses the kernel reset,
// waits a budget derived from n, then returns the kernel result on a stream.
module sum_launcher #(
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned CYC_BASE     = 4,
  parameter int unsigned CYC_PER_ITER = 1,
  parameter logic [31:0] MAX_N        = 32'd1000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_n,
  output logic        kern_rst_n,
  output logic [31:0] kern_n,
  input  logic [31:0] kern_ret,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_n,
  output logic [31:0] out_ret,
  output logic        out_err,
  output logic        busy
);

  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, KRST, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     n_q, n_d;
  logic [RCW-1:0]  rcnt_q, rcnt_d;
  logic [39:0]     run_cnt_q, run_cnt_d;
  logic            kern_rst_n_q, kern_rst_n_d;
  logic            out_valid_q, out_valid_d;
  logic            ack_q, ack_d;
  logic [31:0]     out_n_q, out_n_d;
  logic [31:0]     out_ret_q, out_ret_d;
  logic            out_err_q, out_err_d;
  logic [39:0]     budget;
  logic            accept;
  logic            out_hs;

  assign in_ready   = (state_q == IDLE) && !sys_rst;
  assign busy       = (state_q != IDLE);
  assign kern_rst_n = kern_rst_n_q;
  assign kern_n     = n_q;
  assign out_valid  = out_valid_q;
  assign out_n      = out_n_q;
  assign out_ret    = out_ret_q;
  assign out_err    = out_err_q;

  assign budget = 40'(CYC_BASE) + 40'(CYC_PER_ITER) * {8'd0, n_q};
  assign accept = in_valid && in_ready;
  assign out_hs = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    rcnt_d       = rcnt_q;
    run_cnt_d    = run_cnt_q;
    out_valid_d  = out_valid_q;
    ack_d        = ack_q;
    out_n_d      = out_n_q;
    out_ret_d    = out_ret_q;
    out_err_d    = out_err_q;
    // Registered decode: the kernel sees reset one cycle after KRST is entered.
    kern_rst_n_d = (state_q != KRST);

    case (state_q)
      IDLE: begin
        if (accept) begin
          n_d   = in_n;
          ack_d = 1'b0;
          if (in_n <= MAX_N) begin
            state_d = KRST;
            rcnt_d  = '0;
          end else begin
            state_d   = DONE;
            out_err_d = 1'b1;
            out_ret_d = 32'd0;
            out_n_d   = in_n;
          end
        end
      end
      KRST: begin
        if (rcnt_q == RST_LAST) begin
          run_cnt_d = budget;
          rcnt_d    = '0;
          state_d   = RUN;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      RUN: begin
        if (run_cnt_q == 40'd0) begin
          out_ret_d   = kern_ret;
          out_err_d   = 1'b0;
          out_n_d     = n_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          run_cnt_d = run_cnt_q - 40'd1;
        end
      end
      DONE: begin
        // After the handshake spend one more cycle here so in_ready rises a cycle later.
        if (ack_q) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end else if (out_hs) begin
          out_valid_d = 1'b0;
          ack_d       = 1'b1;
        end else if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      rcnt_q       <= '0;
      run_cnt_q    <= '0;
      kern_rst_n_q <= 1'b0;
      out_valid_q  <= 1'b0;
      ack_q        <= 1'b0;
      out_n_q      <= '0;
      out_ret_q    <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      rcnt_q       <= rcnt_d;
      run_cnt_q    <= run_cnt_d;
      kern_rst_n_q <= kern_rst_n_d;
      out_valid_q  <= out_valid_d;
      ack_q        <= ack_d;
      out_n_q      <= out_n_d;
      out_ret_q    <= out_ret_d;
      out_err_q    <= out_err_d;
    end
  end

endmodule

// File: tb/tb_sum_launcher.sv
// Directed bench for sum_launcher with a kernel stub and a scoreboard monitor.
module tb_sum_launcher;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_n;
  logic        kern_rst_n;
  logic [31:0] kern_n;
  logic [31:0] kern_ret;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_n;
  logic [31:0] out_ret;
  logic        out_err;
  logic        busy;

  typedef struct packed {
    logic [31:0] n;
    logic [31:0] ret;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] kcnt;

  always #5 clk = ~clk;

  sum_launcher dut (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_n      (in_n),
    .kern_rst_n(kern_rst_n),
    .kern_n    (kern_n),
    .kern_ret  (kern_ret),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_n     (out_n),
    .out_ret   (out_ret),
    .out_err   (out_err),
    .busy      (busy)
  );

  // Kernel stub: garbage for n+1 cycles after reset release, then 3*n.
  always @(posedge clk) begin
    if (!kern_rst_n) kcnt <= 32'd0;
    else if (kcnt != 32'hFFFF_FFFF) kcnt <= kcnt + 32'd1;
  end
  assign kern_ret = (kcnt > kern_n) ? kern_n * 32'd3 : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (!sys_rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 64'(out_n), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_n", 64'(out_n), 64'(e.n));
        chk("out_ret", 64'(out_ret), 64'(e.ret));
        chk("out_err", 64'(out_err), 64'(e.err));
        $display("result n=%0d ret=%0d err=%0b", out_n, out_ret, out_err);
      end
    end
  end

  // Presents n until accepted; returns 1ns after the accept edge E0.
  task automatic launch(input logic [31:0] n);
    bit done = 0;
    in_valid = 1'b1;
    in_n     = n;
    for (int i = 0; i < 200 && !done; i++) begin
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
    $display("launch n=%0d", n);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      if (sb_q.size() == 0 && !busy) done = 1;
      else tick();
    end
    if (!done) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic push(input logic [31:0] n, input logic [31:0] ret, input logic err);
    exp_t e;
    e.n = n; e.ret = ret; e.err = err;
    sb_q.push_back(e);
  endtask

  initial begin
    int accepts, hs_cyc, acc2_cyc, kn_bad, ov_seen;
    bit acc, hs;
    logic [31:0] kn_prev;

    sys_rst = 1'b1; in_valid = 1'b0; in_n = 32'd0; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst_kern_rst_n", 64'(kern_rst_n), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outs", {out_n, out_ret}, 64'd0);
    chk("rst_kern_n_err", {kern_n, 31'd0, out_err}, 64'd0);
    sys_rst = 1'b0;
    tick();
    chk("rel_kern_rst_n", 64'(kern_rst_n), 64'd1);
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // 1: basic call, n=10
    push(32'd10, 32'd30, 1'b0);
    launch(32'd10);
    tick(); chk("t1_krst_e1", 64'(kern_rst_n), 64'd0);
    tick(); chk("t1_krst_e2", 64'(kern_rst_n), 64'd0);
    tick(); chk("t1_krst_e3", 64'(kern_rst_n), 64'd1);
    chk("t1_kern_n", 64'(kern_n), 64'd10);
    repeat (13) tick();
    chk("t1_ov_e16", 64'(out_valid), 64'd0);
    tick(); chk("t1_ov_e17", 64'(out_valid), 64'd1);
    tick(); chk("t1_ir_e18", 64'(in_ready), 64'd0);
    tick(); chk("t1_ir_e19", 64'(in_ready), 64'd1);
    wait_idle();

    // 2: zero argument
    push(32'd0, 32'd0, 1'b0);
    launch(32'd0);
    repeat (6) tick();
    chk("t2_ov_e6", 64'(out_valid), 64'd0);
    tick(); chk("t2_ov_e7", 64'(out_valid), 64'd1);
    wait_idle();

    // 3: backpressure, n=5 (budget 9, out_valid after E12)
    out_ready = 1'b0;
    push(32'd5, 32'd15, 1'b0);
    launch(32'd5);
    repeat (11) tick();
    chk("t3_ov_e11", 64'(out_valid), 64'd0);
    tick();
    chk("t3_ov_e12", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold", {out_valid, out_ret[30:0], out_n}, {1'b1, 31'd15, 32'd5});
    end
    out_ready = 1'b1;
    tick();
    chk("t3_post_hs", {62'd0, out_valid, in_ready}, 64'd0);
    tick();
    chk("t3_ir", 64'(in_ready), 64'd1);
    wait_idle();

    // 4: over-range argument
    push(32'd1000001, 32'd0, 1'b1);
    launch(32'd1000001);
    chk("t4_krst_e0", 64'(kern_rst_n), 64'd1);
    tick();
    chk("t4_ov_e1", 64'(out_valid), 64'd1);
    chk("t4_krst_e1", 64'(kern_rst_n), 64'd1);
    wait_idle();

    // 5: reset in RUN at E8, then n=4
    launch(32'd10);
    repeat (7) tick();
    sys_rst = 1'b1;
    tick();
    chk("t5_krst_e8", 64'(kern_rst_n), 64'd0);
    chk("t5_busy_e8", 64'(busy), 64'd0);
    sys_rst = 1'b0;
    tick();
    chk("t5_krst_e9", 64'(kern_rst_n), 64'd1);
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) ov_seen++;
      tick();
    end
    chk("t5_no_result", 64'(ov_seen), 64'd0);
    push(32'd4, 32'd12, 1'b0);
    launch(32'd4);
    wait_idle();

    // 6: back-to-back with in_valid held high
    push(32'd3, 32'd9, 1'b0);
    push(32'd7, 32'd21, 1'b0);
    in_valid = 1'b1; in_n = 32'd3;
    accepts = 0; hs_cyc = -1; acc2_cyc = -1; kn_bad = 0;
    for (int c = 0; c < 300 && !(accepts == 2 && sb_q.size() == 0 && !busy); c++) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      kn_prev = kern_n;
      tick();
      if (hs && hs_cyc < 0) hs_cyc = c;
      if (!acc && kern_n != kn_prev) kn_bad++;
      if (acc) begin
        accepts++;
        $display("accept %0d n=%0d", accepts, kern_n);
        if (accepts == 1) in_n = 32'd7;
        else begin
          acc2_cyc = c;
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("t6_accepts", 64'(accepts), 64'd2);
    chk("t6_kern_n_stable", 64'(kn_bad), 64'd0);
    chk("t6_kern_n", 64'(kern_n), 64'd7);
    chk("t6_reaccept_gap", 64'(acc2_cyc - hs_cyc), 64'd2);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
